tdc_burst_sequencer: RTL and testbench

- Sits above the TDC controller and runs a burst of N back-to-back conversions per request.
- For each conversion it clears the TDC, pulses its start, waits for ready, then accumulates the returned code.
- When the burst completes it reports the full sum; a host divides the sum by N to obtain the average.
- Has a per-conversion timeout and an abort input, so a stuck TDC can never hang the measurement path.

---
 rtl/tdc_burst_sequencer.sv | 162 ++++++++++++++++
 tb/tb_tdc_burst_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_burst_sequencer.sv
// tdc_burst_sequencer: runs a burst of N TDC conversions per request and
// accumulates the returned codes. The host divides the sum by N to get the
// average. A per-conversion timeout and an abort input keep a stuck TDC
// from hanging the measurement path. All outputs are registered.
module tdc_burst_sequencer #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [BURST_W-1:0]       burst_len,
  input  logic                     abort,
  output logic                     tdc_clear,
  output logic                     tdc_start,
  input  logic                     tdc_ready,
  input  logic [CNT_W-1:0]         tdc_code,
  output logic                     busy,
  output logic [CNT_W+BURST_W-1:0] sum,
  output logic                     sum_valid,
  output logic [BURST_W-1:0]       n_done,
  output logic                     timeout_err
);

  localparam int SUM_W = CNT_W + BURST_W;
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC + 1) : 1;

  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   TMR_ONE  = TMR_W'(1);
  localparam logic [CLR_W-1:0]   CLR_LAST = CLR_W'(CLR_CYC - 1);
  localparam logic [CLR_W-1:0]   CLR_ONE  = CLR_W'(1);
  localparam logic [BURST_W-1:0] N_ONE    = BURST_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  logic [BURST_W-1:0] r_len;
  logic [CLR_W-1:0]   r_clr_cnt;
  logic [TMR_W-1:0]   r_timer;
  logic               r_tdc_clear;
  logic               r_tdc_start;
  logic               r_busy;
  logic [SUM_W-1:0]   r_sum;
  logic               r_sum_valid;
  logic [BURST_W-1:0] r_n_done;
  logic               r_timeout_err;

  logic [BURST_W-1:0] w_n_next;
  logic [SUM_W-1:0]   w_sum_next;

  assign w_n_next   = r_n_done + N_ONE;
  assign w_sum_next = r_sum + {{BURST_W{1'b0}}, tdc_code};

  assign tdc_clear   = r_tdc_clear;
  assign tdc_start   = r_tdc_start;
  assign busy        = r_busy;
  assign sum         = r_sum;
  assign sum_valid   = r_sum_valid;
  assign n_done      = r_n_done;
  assign timeout_err = r_timeout_err;

  // Burst sequencing FSM; every output is produced as a registered value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_clr_cnt     <= '0;
      r_timer       <= '0;
      r_tdc_clear   <= 1'b0;
      r_tdc_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_sum         <= '0;
      r_sum_valid   <= 1'b0;
      r_n_done      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      // single-cycle pulses fall back to 0 unless a state re-asserts them
      r_tdc_start <= 1'b0;
      r_sum_valid <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        // abort overrides ready and timeout; results and error flag are kept
        r_state     <= S_IDLE;
        r_tdc_clear <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (req && (burst_len != '0)) begin
              r_len         <= burst_len;
              r_sum         <= '0;
              r_n_done      <= '0;
              r_timeout_err <= 1'b0;
              r_clr_cnt     <= '0;
              r_tdc_clear   <= 1'b1;
              r_busy        <= 1'b1;
              r_state       <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            if (r_clr_cnt == CLR_LAST) begin
              r_tdc_clear <= 1'b0;
              r_tdc_start <= 1'b1;
              r_state     <= S_START;
            end else begin
              r_clr_cnt <= r_clr_cnt + CLR_ONE;
            end
          end
          S_START: begin
            r_timer <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (tdc_ready) begin
              // ready wins over a coincident timeout
              r_sum    <= w_sum_next;
              r_n_done <= w_n_next;
              if (w_n_next == r_len) begin
                r_sum_valid <= 1'b1;
                r_state     <= S_DONE;
              end else begin
                r_clr_cnt   <= '0;
                r_tdc_clear <= 1'b1;
                r_state     <= S_CLEAR;
              end
            end else if (r_timer == TMR_LAST) begin
              r_timeout_err <= 1'b1;
              r_tdc_clear   <= 1'b1;
              r_state       <= S_ERR;
            end else begin
              r_timer <= r_timer + TMR_ONE;
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          S_ERR: begin
            r_tdc_clear <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
          default: begin
            r_tdc_clear <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdc_burst_sequencer.sv
// Testbench for tdc_burst_sequencer: the bench plays the TDC controller,
// serving each start with a chosen delay and code, and compares the DUT
// against sums, counts and latencies derived from the burst rules.
module tb_tdc_burst_sequencer;
  localparam int CNT_W   = 8;
  localparam int BURST_W = 4;
  localparam int CLR_CYC = 2;
  localparam int TIMEOUT = 64;
  localparam int SUM_W   = CNT_W + BURST_W;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               req = 1'b0;
  logic               abort = 1'b0;
  logic               tdc_ready = 1'b0;
  logic [BURST_W-1:0] burst_len = '0;
  logic [CNT_W-1:0]   tdc_code = '0;
  logic               tdc_clear, tdc_start, busy, sum_valid, timeout_err;
  logic [SUM_W-1:0]   sum;
  logic [BURST_W-1:0] n_done;

  int n_chk = 0;
  int n_err = 0;
  int mon_starts = 0;
  int mon_sv = 0;

  tdc_burst_sequencer #(
    .CNT_W(CNT_W), .BURST_W(BURST_W), .CLR_CYC(CLR_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .burst_len(burst_len), .abort(abort),
    .tdc_clear(tdc_clear), .tdc_start(tdc_start), .tdc_ready(tdc_ready),
    .tdc_code(tdc_code), .busy(busy), .sum(sum), .sum_valid(sum_valid),
    .n_done(n_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // count start pulses and sum_valid pulses seen over the whole run
  always @(negedge clk) begin
    if (tdc_start === 1'b1) mon_starts <= mon_starts + 1;
    if (sum_valid === 1'b1) mon_sv <= mon_sv + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_burst(input int len);
    burst_len = BURST_W'(len);
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (tdc_start === 1'b1) ok = 1'b1;
      else step();
    end
  endtask

  // answer one conversion: ready is sampled in WAIT cycle d (timer == d)
  task automatic serve(input int d, input logic [CNT_W-1:0] code, output bit ok);
    wait_start(ok);
    if (ok) begin
      repeat (d + 1) step();
      tdc_ready = 1'b1;
      tdc_code  = code;
      step();
      tdc_ready = 1'b0;
      tdc_code  = CNT_W'($urandom);
    end
  endtask

  task automatic wait_done(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (sum_valid === 1'b1) ok = 1'b1;
      else begin step(); waited++; end
    end
  endtask

  task automatic test_reset();
    int s0;
    rst = 1'b0;
    step(); step();
    n_chk++; if ({tdc_clear, tdc_start, busy, sum_valid, timeout_err, sum, n_done} !== '0) begin
      n_err++; $display("FAIL reset_held: outputs=%h want 0", {tdc_clear, tdc_start, busy, sum_valid, timeout_err, sum, n_done}); end
    rst = 1'b1;
    step();
    n_chk++; if ({tdc_clear, tdc_start, busy, sum_valid, timeout_err, sum, n_done} !== '0) begin
      n_err++; $display("FAIL reset_release: outputs=%h want 0", {tdc_clear, tdc_start, busy, sum_valid, timeout_err, sum, n_done}); end
    s0 = mon_starts;
    start_burst(0);
    n_chk++; if ({busy, tdc_clear} !== 2'b00) begin
      n_err++; $display("FAIL len0_ignored: busy,clear=%b want 00", {busy, tdc_clear}); end
    repeat (5) step();
    n_chk++; if (mon_starts - s0 !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL len0_no_start: starts=%0d busy=%b want 0 0", mon_starts - s0, busy); end
  endtask

  task automatic test_single();
    int s0, v0, waited;
    bit ok;
    s0 = mon_starts; v0 = mon_sv;
    start_burst(1);
    n_chk++; if ({tdc_clear, tdc_start, busy} !== 3'b101) begin
      n_err++; $display("FAIL single_clr1: clear,start,busy=%b want 101", {tdc_clear, tdc_start, busy}); end
    step();
    n_chk++; if ({tdc_clear, tdc_start} !== 2'b10) begin
      n_err++; $display("FAIL single_clr2: clear,start=%b want 10", {tdc_clear, tdc_start}); end
    step();
    n_chk++; if ({tdc_clear, tdc_start} !== 2'b01) begin
      n_err++; $display("FAIL single_start: clear,start=%b want 01", {tdc_clear, tdc_start}); end
    serve(4, 8'h2A, ok);
    wait_done(ok, waited);
    n_chk++; if (!ok || waited != 0) begin
      n_err++; $display("FAIL single_latency: seen=%0d waited=%0d want 1 0", ok, waited); end
    n_chk++; if (sum !== SUM_W'(42) || n_done !== BURST_W'(1)) begin
      n_err++; $display("FAIL single_result: sum=%0d n_done=%0d want 42 1", sum, n_done); end
    step();
    n_chk++; if ({sum_valid, busy} !== 2'b00 || sum !== SUM_W'(42)) begin
      n_err++; $display("FAIL single_after: sv,busy=%b sum=%0d want 00 42", {sum_valid, busy}, sum); end
    n_chk++; if (mon_starts - s0 != 1 || mon_sv - v0 != 1) begin
      n_err++; $display("FAIL single_counts: starts=%0d sv=%0d want 1 1", mon_starts - s0, mon_sv - v0); end
  endtask

  task automatic test_max_burst();
    int s0, v0, good, waited;
    bit ok;
    s0 = mon_starts; v0 = mon_sv; good = 0;
    start_burst(15);
    for (int i = 0; i < 15; i++) begin
      serve(int'($urandom_range(0, 5)), 8'hFF, ok);
      if (ok) good++;
    end
    wait_done(ok, waited);
    n_chk++; if (!ok || good != 15) begin
      n_err++; $display("FAIL max_flow: served=%0d done=%0d want 15 1", good, ok); end
    n_chk++; if (sum !== SUM_W'(3825) || n_done !== BURST_W'(15)) begin
      n_err++; $display("FAIL max_result: sum=%0d n_done=%0d want 3825 15", sum, n_done); end
    repeat (3) step();
    n_chk++; if (mon_starts - s0 != 15 || mon_sv - v0 != 1) begin
      n_err++; $display("FAIL max_counts: starts=%0d sv=%0d want 15 1", mon_starts - s0, mon_sv - v0); end
  endtask

  task automatic test_random_bursts();
    int s0, v0, len, exp_sum, good, waited;
    logic [CNT_W-1:0] codes[$];
    bit ok;
    for (int it = 0; it < 5; it++) begin
      s0 = mon_starts; v0 = mon_sv;
      len = int'($urandom_range(1, 15));
      codes.delete();
      for (int i = 0; i < len; i++) codes.push_back(CNT_W'($urandom));
      exp_sum = 0;
      foreach (codes[i]) exp_sum += int'(codes[i]);
      good = 0;
      start_burst(len);
      foreach (codes[i]) begin
        serve(int'($urandom_range(0, 12)), codes[i], ok);
        if (ok) good++;
      end
      wait_done(ok, waited);
      n_chk++; if (!ok || good != len || sum !== SUM_W'(exp_sum) || n_done !== BURST_W'(len)) begin
        n_err++; $display("FAIL rand_result[%0d]: sum=%0d n_done=%0d want %0d %0d", it, sum, n_done, exp_sum, len); end
      repeat (2) step();
      n_chk++; if (mon_starts - s0 != len || mon_sv - v0 != 1 || timeout_err !== 1'b0) begin
        n_err++; $display("FAIL rand_counts[%0d]: starts=%0d sv=%0d terr=%b want %0d 1 0", it, mon_starts - s0, mon_sv - v0, timeout_err, len); end
    end
  endtask

  task automatic test_timeout();
    int v0, cnt, waited;
    logic [CNT_W-1:0] c;
    bit ok;
    v0 = mon_sv;
    start_burst(3);
    serve(3, 8'd10, ok);
    wait_start(ok);
    cnt = 0;
    while (timeout_err !== 1'b1 && cnt < 80) begin step(); cnt++; end
    n_chk++; if (cnt != TIMEOUT + 1) begin
      n_err++; $display("FAIL timeout_delay: cycles=%0d want %0d", cnt, TIMEOUT + 1); end
    n_chk++; if ({tdc_clear, busy} !== 2'b11) begin
      n_err++; $display("FAIL timeout_err_state: clear,busy=%b want 11", {tdc_clear, busy}); end
    step();
    n_chk++; if ({busy, tdc_clear, timeout_err} !== 3'b001 || n_done !== BURST_W'(1) || sum !== SUM_W'(10)) begin
      n_err++; $display("FAIL timeout_after: busy,clear,terr=%b n_done=%0d sum=%0d want 001 1 10", {busy, tdc_clear, timeout_err}, n_done, sum); end
    n_chk++; if (mon_sv - v0 != 0) begin
      n_err++; $display("FAIL timeout_no_sv: sv=%0d want 0", mon_sv - v0); end
    c = CNT_W'($urandom);
    start_burst(1);
    n_chk++; if (timeout_err !== 1'b0 || sum !== '0) begin
      n_err++; $display("FAIL timeout_clear: terr=%b sum=%0d want 0 0", timeout_err, sum); end
    serve(0, c, ok);
    wait_done(ok, waited);
    n_chk++; if (!ok || sum !== SUM_W'(c)) begin
      n_err++; $display("FAIL timeout_recover: sum=%0d want %0d", sum, c); end
    step();
  endtask

  task automatic test_abort();
    int s0, v0, waited;
    logic [CNT_W-1:0] c1, c2;
    bit ok;
    s0 = mon_starts; v0 = mon_sv;
    c1 = CNT_W'($urandom);
    start_burst(4);
    serve(2, c1, ok);
    wait_start(ok);
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_chk++; if ({busy, tdc_clear, timeout_err} !== 3'b000 || n_done !== BURST_W'(1) || sum !== SUM_W'(c1)) begin
      n_err++; $display("FAIL abort_state: busy,clear,terr=%b n_done=%0d sum=%0d want 000 1 %0d", {busy, tdc_clear, timeout_err}, n_done, sum, c1); end
    repeat (6) step();
    n_chk++; if (mon_sv - v0 != 0 || mon_starts - s0 != 2 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_quiet: sv=%0d starts=%0d busy=%b want 0 2 0", mon_sv - v0, mon_starts - s0, busy); end
    c2 = CNT_W'($urandom);
    abort = 1'b1;
    start_burst(1);
    abort = 1'b0;
    n_chk++; if (busy !== 1'b1) begin
      n_err++; $display("FAIL abort_idle: busy=%b want 1", busy); end
    serve(0, c2, ok);
    wait_done(ok, waited);
    n_chk++; if (!ok || sum !== SUM_W'(c2)) begin
      n_err++; $display("FAIL abort_idle_sum: sum=%0d want %0d", sum, c2); end
    step();
  endtask

  task automatic test_ignored_req();
    int s0, exp_sum, good, waited;
    logic [CNT_W-1:0] c;
    bit ok;
    s0 = mon_starts; exp_sum = 0; good = 0;
    start_burst(4);
    for (int i = 0; i < 4; i++) begin
      c = CNT_W'($urandom);
      exp_sum += int'(c);
      serve(int'($urandom_range(0, 4)), c, ok);
      if (ok) good++;
      if (i == 0) begin
        burst_len = BURST_W'(1);
        req = 1'b1;
        step();
        req = 1'b0;
      end
    end
    wait_done(ok, waited);
    n_chk++; if (!ok || good != 4 || n_done !== BURST_W'(4) || sum !== SUM_W'(exp_sum)) begin
      n_err++; $display("FAIL ignored_req: n_done=%0d sum=%0d want 4 %0d", n_done, sum, exp_sum); end
    step();
    n_chk++; if (mon_starts - s0 != 4) begin
      n_err++; $display("FAIL ignored_req_starts: starts=%0d want 4", mon_starts - s0); end
  endtask

  task automatic test_boundary();
    int v0, waited;
    logic [CNT_W-1:0] c1, c2;
    bit ok;
    v0 = mon_sv;
    c1 = CNT_W'($urandom);
    c2 = CNT_W'($urandom);
    start_burst(2);
    serve(TIMEOUT - 1, c1, ok);
    n_chk++; if (!ok || timeout_err !== 1'b0 || n_done !== BURST_W'(1) || sum !== SUM_W'(c1)) begin
      n_err++; $display("FAIL edge_ready: terr=%b n_done=%0d sum=%0d want 0 1 %0d", timeout_err, n_done, sum, c1); end
    serve(0, c2, ok);
    wait_done(ok, waited);
    n_chk++; if (!ok || sum !== SUM_W'(int'(c1) + int'(c2)) || timeout_err !== 1'b0) begin
      n_err++; $display("FAIL edge_done: sum=%0d terr=%b want %0d 0", sum, timeout_err, int'(c1) + int'(c2)); end
    step();
    // reset during CLEAR returns everything to zero without waiting for a clock
    start_burst(5);
    n_chk++; if (tdc_clear !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_pre: clear=%b want 1", tdc_clear); end
    #1 rst = 1'b0;
    #1;
    n_chk++; if ({tdc_clear, tdc_start, busy, sum_valid, timeout_err, sum, n_done} !== '0) begin
      n_err++; $display("FAIL rst_mid_async: outputs=%h want 0", {tdc_clear, tdc_start, busy, sum_valid, timeout_err, sum, n_done}); end
    step(); step();
    rst = 1'b1;
    repeat (4) step();
    n_chk++; if (busy !== 1'b0 || mon_sv - v0 != 1) begin
      n_err++; $display("FAIL rst_mid_after: busy=%b sv=%0d want 0 1", busy, mon_sv - v0); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_max_burst();
    test_random_bursts();
    test_timeout();
    test_abort();
    test_ignored_req();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
